// File: rtl/if_fetch_buf_if.sv
// Fetch-buffer bus: ROM fetch port, branch/jump redirect and the ID-side valid/ready head entry.
// slave = the fetch buffer itself, master = the surrounding pipeline/ROM.
interface if_fetch_buf_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_data_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic [CNT_W-1:0]  fill_o;

  modport slave (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fill_o,
    input  rom_data_i, redirect_i, redirect_pc_i, id_ready_i
  );

  modport master (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fill_o,
    output rom_data_i, redirect_i, redirect_pc_i, id_ready_i
  );
endinterface

// File: rtl/if_fetch_buf.sv
// Fetch PC generator plus DEPTH-entry {pc, inst} FIFO; entry visible to ID one cycle after fetch.
// Fetch stalls (PC holds) only when full and ID does not pop; redirect flushes and reloads the PC.
module if_fetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4,
  parameter int                CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  if_fetch_buf_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            head;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rom_ce_q, rom_ce_d;

  logic              valid;
  logic              full;
  logic              pop;
  logic              push;

  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = valid & bus.id_ready_i;
  // A pop frees a slot in the same edge, so a full buffer keeps fetching while ID drains.
  assign push  = rom_ce_q & ~bus.redirect_i & (~full | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rom_ce_d   = 1'b1;
    if (bus.redirect_i) begin
      fetch_pc_d = bus.redirect_pc_i;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rom_ce_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rom_ce_q   <= rom_ce_d;
    end
  end

  // Storage needs no reset: count_q gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, inst: bus.rom_data_i};
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.rom_ce_o   = rom_ce_q;
  assign bus.rom_addr_o = fetch_pc_q;
  assign bus.id_valid_o = valid;
  assign bus.id_pc_o    = valid ? head.pc   : '0;
  assign bus.id_inst_o  = valid ? head.inst : '0;
  assign bus.fill_o     = count_q;

  a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
endmodule
